// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, drives instruction memory, and buffers fetched words in a 2-entry queue toward decode.
// Optional FETCH_PERF_EN adds the perf_fetched / perf_flushed counters.
module fetch_controller #(
  parameter int              XLEN         = 32,
  parameter int              WORD_ADDRESS = 8,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt_req,
  output logic [WORD_ADDRESS-1:0] imem_address,
  input  logic [XLEN-1:0]         imem_instruction,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_instruction,
  output logic [XLEN-1:0]         out_pc,
  output logic                    halted,
`ifdef FETCH_PERF_EN
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_flushed,
`endif
  output logic [1:0]              o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  // Handshake: the head entry transfers on a rising clk edge when out_valid && out_ready;
  // out_valid never depends on out_ready, and a redirect cycle suppresses out_valid.

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_q_instr [2];
  logic [XLEN-1:0] r_q_pc    [2];
  logic            r_head;
  logic [1:0]      r_count;

  logic            w_pop;
  logic            w_space;
  logic            w_fetch;
  logic            w_tail;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;

  assign out_valid       = (r_count != 2'd0) && !redirect;
  assign w_pop           = out_valid && out_ready;
  assign w_space         = (r_count < 2'd2) || w_pop;
  // halt_req blocks fetches immediately so the drain only delivers what is already queued.
  assign w_fetch         = (r_state == S_RUN) && !redirect && !halt_req && w_space;
  assign w_tail          = r_head ^ r_count[0];
  assign w_target        = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_pc_inc        = r_pc + {{(XLEN-3){1'b0}}, 3'b100};

  assign imem_address    = r_pc[WORD_ADDRESS+1:2];
  assign out_instruction = r_q_instr[r_head];
  assign out_pc          = r_q_pc[r_head];
  assign halted          = (r_state == S_HALTED);
  assign o_dbg_state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (halt_req) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_count == 2'd0) w_state_nxt = S_HALTED;
      S_HALTED: if (start) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        // Queue is always empty in IDLE, so clearing it unconditionally is harmless there.
        r_pc    <= w_target;
        r_count <= 2'd0;
      end else begin
        if (w_fetch) begin
          r_q_instr[w_tail] <= imem_instruction;
          r_q_pc[w_tail]    <= r_pc;
          r_pc              <= w_pc_inc;
        end
        if (w_pop) r_head <= ~r_head;
        r_count <= r_count + {1'b0, w_fetch} - {1'b0, w_pop};
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_fetch) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect) r_perf_flushed <= r_perf_flushed + {30'd0, r_count};
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational instruction memory model.
// Expected values are hand-computed per cycle.
module tb_fetch_controller;

  localparam int          XLEN         = 32;
  localparam int          WORD_ADDRESS = 8;
  localparam int          MEM_SIZE     = 32;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    halt_req;
  logic [WORD_ADDRESS-1:0] imem_address;
  logic [XLEN-1:0]         imem_instruction;
  logic                    redirect;
  logic [XLEN-1:0]         redirect_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_instruction;
  logic [XLEN-1:0]         out_pc;
  logic                    halted;
  logic [1:0]              dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]             perf_fetched;
  logic [31:0]             perf_flushed;
`endif

  logic [31:0] mem [MEM_SIZE];
  int checks;
  int errors;

  fetch_controller #(
    .XLEN(XLEN), .WORD_ADDRESS(WORD_ADDRESS), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .halted(halted),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
    .o_dbg_state(dbg_state)
  );

  assign imem_instruction = (int'(imem_address) < MEM_SIZE) ? mem[imem_address[4:0]] : NOP;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'h0A00_0000 + i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instruction, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr", {24'd0, imem_address}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    check("idle_no_fetch", {24'd0, imem_address}, 32'd0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stream_first_gap", {31'd0, out_valid}, 32'd0);
    tick();
    check("stream_v0", {31'd0, out_valid}, 32'd1);
    check("stream_pc0", out_pc, 32'h0);
    check("stream_i0", out_instruction, 32'h0000_0013);
    tick();
    check("stream_pc1", out_pc, 32'h4);
    check("stream_i1", out_instruction, 32'h0010_0093);
    tick();
    check("stream_pc2", out_pc, 32'h8);
    check("stream_i2", out_instruction, 32'h0A00_0002);
    check("stream_v2", {31'd0, out_valid}, 32'd1);

    // Backpressure: two entries then stall
    do_reset();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_addr_hold", {24'd0, imem_address}, 32'd2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", out_pc, 32'h0);
    out_ready = 1'b1;
    settle();
    check("bp_rel0", out_pc, 32'h0);
    tick();
    check("bp_rel1", out_pc, 32'h4);
    tick();
    check("bp_rel2", out_pc, 32'h8);
    check("bp_rel2_v", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_rel3", out_pc, 32'hC);

    // Redirect with a full queue
    do_reset();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rd_pre_valid", {31'd0, out_valid}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h43;
    settle();
    check("rd_kill_valid", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    check("rd_gap_valid", {31'd0, out_valid}, 32'd0);
    check("rd_addr", {24'd0, imem_address}, 32'h10);
    tick();
    check("rd_valid", {31'd0, out_valid}, 32'd1);
    check("rd_pc", out_pc, 32'h40);
    check("rd_instr", out_instruction, 32'h0A00_0010);
`ifdef FETCH_PERF_EN
    check("perf_flushed", perf_flushed, 32'd2);
    check("perf_fetched", perf_fetched, 32'd3);
`endif

    // Halt with two entries queued, then resume
    do_reset();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("halt_pre_addr", {24'd0, imem_address}, 32'd2);
    halt_req = 1'b1;
    out_ready = 1'b1;
    settle();
    check("halt_d0", out_pc, 32'h0);
    tick();
    check("halt_state_drain", {30'd0, dbg_state}, 32'd2);
    check("halt_d1", out_pc, 32'h4);
    check("halt_d1_v", {31'd0, out_valid}, 32'd1);
    tick();
    check("halt_empty", {31'd0, out_valid}, 32'd0);
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_addr", {24'd0, imem_address}, 32'd2);
    tick();
    check("halt_stays", {31'd0, halted}, 32'd1);
    check("halt_no_valid", {31'd0, out_valid}, 32'd0);
    halt_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_state", {30'd0, dbg_state}, 32'd1);
    tick();
    check("resume_pc", out_pc, 32'h8);
    check("resume_instr", out_instruction, 32'h0A00_0002);

    // Past end of memory, then PC wrap
    redirect = 1'b1;
    redirect_pc = 32'h7C;
    settle();
    check("end_kill", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    tick();
    check("end_pc31", out_pc, 32'h7C);
    check("end_i31", out_instruction, 32'h0A00_001F);
    tick();
    check("end_pc32", out_pc, 32'h80);
    check("end_nop", out_instruction, NOP);
    tick();
    check("end_pc33", out_pc, 32'h84);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_top_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_top_nop", out_instruction, NOP);
    tick();
    check("wrap_pc0", out_pc, 32'h0);
    check("wrap_i0", out_instruction, 32'h0000_0013);
    tick();
    check("wrap_pc4", out_pc, 32'h4);
    check("wrap_i4", out_instruction, 32'h0010_0093);

    // Reset mid-stream with a full queue
    out_ready = 1'b0;
    tick();
    check("mrst_full", {31'd0, out_valid}, 32'd1);
    check("mrst_head", out_pc, 32'h4);
    check("mrst_addr_pre", {24'd0, imem_address}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_halted", {31'd0, halted}, 32'd0);
    check("mrst_addr", {24'd0, imem_address}, 32'd0);
    check("mrst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    tick();
    check("mrst_idle_addr", {24'd0, imem_address}, 32'd0);
    check("mrst_idle_valid", {31'd0, out_valid}, 32'd0);

    // Simultaneous halt and redirect
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("hr_pre_valid", {31'd0, out_valid}, 32'd1);
    halt_req = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h20;
    settle();
    check("hr_kill", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    check("hr_state", {30'd0, dbg_state}, 32'd2);
    check("hr_addr", {24'd0, imem_address}, 32'd8);
    check("hr_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("hr_halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
